// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives a 1-cycle synchronous ROM, buffers words in a prefetch FIFO.
// Issue-to-valid latency is 2 cycles; fetch issue is credit-limited so a ROM return always has a free slot.
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_read_enable,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem_dat_q [DEPTH];
  logic [ADDR_W-1:0] mem_pc_q  [DEPTH];
  logic [DATA_W-1:0] last_dat_q;
  logic [ADDR_W-1:0] last_pc_q;

  logic          pop, push, issue;
  logic [CW:0]   credit;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;
  // A return in the redirect cycle belongs to the old stream and is killed.
  assign push        = inflight_q & ~redirect;
  assign credit      = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue       = reset & ~halt & (redirect | (credit < (CW+1)'(DEPTH)));

  assign rom_read_enable = issue;
  assign rom_address     = (reset & redirect) ? redirect_pc : pc_q;
  assign pc              = pc_q;

  // Once empty, the outputs keep showing the last word that was consumed.
  assign instr_out = instr_valid ? mem_dat_q[rd_ptr_q] : last_dat_q;
  assign instr_pc  = instr_valid ? mem_pc_q[rd_ptr_q]  : last_pc_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    wr_ptr_d      = wr_ptr_q + PW'(push);
    count_d       = count_q + CW'(push) - CW'(pop);
    if (issue) begin
      inflight_pc_d = rom_address;
      pc_d          = rom_address + ADDR_W'(1);
    end else if (redirect) begin
      pc_d = redirect_pc;
    end
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      last_dat_q    <= '0;
      last_pc_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_dat_q[i] <= '0;
        mem_pc_q[i]  <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      if (pop) begin
        last_dat_q <= instr_out;
        last_pc_q  <= instr_pc;
      end
      if (push) begin
        mem_dat_q[wr_ptr_q] <= rom_data;
        mem_pc_q[wr_ptr_q]  <= inflight_pc_q;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit; an in-order PC scoreboard checks every consumed word.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rom_address;
  logic        rom_read_enable;
  logic [15:0] rom_data = '0;
  logic [15:0] instr_out;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halt;
  logic [7:0]  pc;

  fetch_unit dut (
    .clk(clk), .reset(reset), .rom_address(rom_address), .rom_read_enable(rom_read_enable),
    .rom_data(rom_data), .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .pc(pc)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  always @(posedge clk) if (rom_read_enable) rom_data <= rom[rom_address];

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_pc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample point: consumed words must follow the PC sequence started by the last redirect/reset.
  task automatic half();
    @(negedge clk);
    if (reset) begin
      if (instr_valid && instr_ready) begin
        chk("sb_pc", 32'(instr_pc), 32'(exp_pc));
        chk("sb_dat", 32'(instr_out), 32'(rom[exp_pc]));
        exp_pc = exp_pc + 8'd1;
      end
      if (redirect) exp_pc = redirect_pc;
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      half();
      edge_();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_pc = '0;
    tick(2);
  endtask

  initial begin
    logic [7:0] saved_pc;
    logic [7:0] w;
    logic       seen;

    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
    instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    do_reset();

    // reset values
    half();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_raddr", 32'(rom_address), 32'h0);
    chk("rst_rre", 32'(rom_read_enable), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_out", 32'(instr_out), 32'h0);
    chk("rst_ipc", 32'(instr_pc), 32'h0);
    edge_();

    // streaming after release
    reset = 1'b1;
    half(); chk("c0_rre", 32'(rom_read_enable), 32'h1); chk("c0_valid", 32'(instr_valid), 32'h0); edge_();
    half(); chk("c1_rre", 32'(rom_read_enable), 32'h1); chk("c1_valid", 32'(instr_valid), 32'h0); edge_();
    for (int k = 0; k < 3; k++) begin
      half();
      chk("str_valid", 32'(instr_valid), 32'h1);
      chk("str_out", 32'(instr_out), 32'h1000 + 32'(k));
      chk("str_rre", 32'(rom_read_enable), 32'h1);
      edge_();
    end

    // backpressure
    do_reset();
    reset = 1'b1;
    tick(2);
    instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      half();
      chk("bp_valid", 32'(instr_valid), 32'h1);
      chk("bp_out", 32'(instr_out), 32'h1000);
      chk("bp_ipc", 32'(instr_pc), 32'h0);
      chk("bp_rre", 32'(rom_read_enable), 32'h0);
      edge_();
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      half();
      chk("bp_drain_valid", 32'(instr_valid), 32'h1);
      chk("bp_drain_out", 32'(instr_out), 32'h1000 + 32'(k));
      edge_();
    end

    // redirect with buffered entries and one fetch in flight
    instr_ready = 1'b0; tick(3);
    instr_ready = 1'b1; tick(1);
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h40;
    half(); chk("rd_rre", 32'(rom_read_enable), 32'h1); chk("rd_raddr", 32'(rom_address), 32'h40); edge_();
    redirect = 1'b0;
    half(); chk("rd_gap", 32'(instr_valid), 32'h0); chk("rd_pc", 32'(pc), 32'h41); edge_();
    half();
    chk("rd_valid", 32'(instr_valid), 32'h1);
    chk("rd_out", 32'(instr_out), 32'(rom[8'h40]));
    chk("rd_ipc", 32'(instr_pc), 32'h40);
    edge_();

    // PC wrap
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'hFE;
    tick(1);
    redirect = 1'b0;
    half(); chk("wr_gap", 32'(instr_valid), 32'h0); edge_();
    for (int k = 0; k < 4; k++) begin
      w = 8'hFE + 8'(k);
      half(); chk("wr_ipc", 32'(instr_pc), 32'(w)); chk("wr_valid", 32'(instr_valid), 32'h1); edge_();
    end

    // halt with a fetch in flight
    halt = 1'b1;
    half(); saved_pc = pc; chk("h_rre0", 32'(rom_read_enable), 32'h0); edge_();
    half(); chk("h_last_word", 32'(instr_valid), 32'h1); chk("h_rre1", 32'(rom_read_enable), 32'h0); edge_();
    for (int k = 0; k < 3; k++) begin
      half(); chk("h_rre", 32'(rom_read_enable), 32'h0); chk("h_empty", 32'(instr_valid), 32'h0); edge_();
    end
    halt = 1'b0;
    half();
    chk("h_resume_rre", 32'(rom_read_enable), 32'h1);
    chk("h_resume_addr", 32'(rom_address), 32'(saved_pc));
    edge_();
    tick(4);

    // asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 32'(instr_valid), 32'h0);
    chk("ar_pc", 32'(pc), 32'h0);
    chk("ar_rre", 32'(rom_read_enable), 32'h0);
    exp_pc = '0;
    edge_();
    tick(2);
    reset = 1'b1;
    tick(2);
    half(); chk("ar_out", 32'(instr_out), 32'h1000); chk("ar_ipc", 32'(instr_pc), 32'h0); edge_();

    // randomized traffic against the scoreboard
    reset = 1'b0;
    exp_pc = '0;
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    tick(2);
    reset = 1'b1;
    for (int c = 0; c < 600; c++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 14) == 0) halt = ~halt;
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = 8'($urandom);
      half();
      chk("rnd_raddr", 32'(rom_address), redirect ? 32'(redirect_pc) : 32'(pc));
      if (halt) chk("rnd_halt_rre", 32'(rom_read_enable), 32'h0);
      edge_();
    end
    halt = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      half();
      if (instr_valid) seen = 1'b1;
      edge_();
    end
    chk("rnd_live", 32'(seen), 32'h1);
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
